// File: rtl/arb4.sv
`default_nettype none
// ============================================================================
// Module   : arb4
// Brief    : Four-way round-robin arbiter with registered one-hot grants.
//            Optional forced release after MAX_HOLD cycles (ARB4_TIMEOUT_EN).
// Revision : 1.0
// ============================================================================
module arb4 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       x0,
    input  logic       x1,
    input  logic       x2,
    input  logic       x3,
    output logic       z0,
    output logic       z1,
    output logic       z2,
    output logic       z3,
    output logic       z_any,
    output logic [1:0] gid,
    output logic       tmo
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

    state_t     r_state;
    logic [3:0] r_grant;
    logic       r_any;
    logic [1:0] r_gid;
    logic [1:0] r_ptr;
    logic       r_tmo;

    logic [3:0] w_req;
    logic       w_owner_req;
    logic       w_force;
    logic       w_release;
    logic [1:0] w_base;
    logic [3:0] w_cand;
    logic       w_found;
    logic [1:0] w_sel;
    logic [1:0] w_idx;

    assign w_req       = {x3, x2, x1, x0};
    assign w_owner_req = w_req[r_gid];

`ifdef ARB4_TIMEOUT_EN
    logic [7:0] r_cnt;

    assign w_force = (r_state == BUSY) && w_owner_req && (r_cnt == c_max_hold);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= 8'd0;
        end else if (w_found && ((r_state == IDLE) || w_release)) begin
            r_cnt <= 8'd1;
        end else if (w_release) begin
            r_cnt <= 8'd0;
        end else if ((r_state == BUSY) && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
`else
    logic w_unused;

    assign w_force  = 1'b0;
    assign w_unused = ^c_max_hold;
`endif

    assign w_release = (r_state == BUSY) && (!w_owner_req || w_force);
    assign w_base    = w_release ? (r_gid + 2'd1) : r_ptr;
    // A timed-out owner sits out the handoff edge so it cannot re-grab the resource.
    assign w_cand    = w_force ? (w_req & ~r_grant) : w_req;

    always_comb begin
        w_found = 1'b0;
        w_sel   = w_base;
        w_idx   = w_base;
        for (int i = 3; i >= 0; i--) begin
            w_idx = w_base + 2'(i);
            if (w_cand[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_grant <= 4'b0000;
            r_any   <= 1'b0;
            r_gid   <= 2'd0;
            r_ptr   <= 2'd0;
            r_tmo   <= 1'b0;
        end else begin
            r_tmo <= w_force;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= BUSY;
                        r_grant <= 4'b0001 << w_sel;
                        r_any   <= 1'b1;
                        r_gid   <= w_sel;
                    end
                end
                BUSY: begin
                    if (w_release) begin
                        r_ptr <= r_gid + 2'd1;
                        if (w_found) begin
                            r_grant <= 4'b0001 << w_sel;
                            r_any   <= 1'b1;
                            r_gid   <= w_sel;
                        end else begin
                            r_state <= IDLE;
                            r_grant <= 4'b0000;
                            r_any   <= 1'b0;
                            r_gid   <= 2'd0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign z0    = r_grant[0];
    assign z1    = r_grant[1];
    assign z2    = r_grant[2];
    assign z3    = r_grant[3];
    assign z_any = r_any;
    assign gid   = r_gid;
    assign tmo   = r_tmo;

endmodule
`default_nettype wire
